// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, sequencer states and
// the carry-seed rule used to start the subtract/compare chain.
package serial_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    // Subtract and both compares run as a + ~b + 1, so they seed the carry with 1.
    function automatic logic carry_seed(input logic [3:0] op);
        return op[1] | op[3];
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational SLICE-bit ALU step: adds/logic on one slice and advances the
// registered carry and compare chains owned by the sequencer.
module serial_alu_slice
    import serial_alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [3:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cy_in,
    input  logic             cmp_in,
    input  logic             is_last,
    output logic [SLICE-1:0] res,
    output logic             cy_out,
    output logic             cmp_out
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum;
    logic             lt_signed;

    always_comb begin
        b_eff  = carry_seed(op) ? ~b_s : b_s;
        sum    = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, cy_in};
        cy_out = sum[SLICE];
        // Only meaningful on the top slice, where a_s/b_s hold the sign bits.
        lt_signed = (a_s[SLICE-1] != b_s[SLICE-1]) ? a_s[SLICE-1] : ~sum[SLICE];

        res     = '0;
        cmp_out = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res     = sum[SLICE-1:0];
                cmp_out = cmp_in & (sum[SLICE-1:0] == '0);
            end
            OP_SLTU: begin
                cmp_out = is_last ? ~sum[SLICE] : cmp_in;
                res[0]  = cmp_out;
            end
            OP_SLT: begin
                cmp_out = is_last ? lt_signed : cmp_in;
                res[0]  = cmp_out;
            end
            OP_XOR: res = a_s ^ b_s;
            OP_OR:  res = a_s | b_s;
            OP_AND: res = a_s & b_s;
            default: begin
                res     = '0;
                cmp_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: captures an operation on start, walks the operands
// LSB-first one slice per cycle and reports d/cmp with a busy/done handshake.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             cmp
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    if (SLICE < 1 || (WIDTH % SLICE) != 0 || (SLICE & (SLICE - 1)) != 0) begin : g_bad_param
        $error("serial_alu_seq: SLICE must be a power of two that divides WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cy_q, chain_q;
    logic [WIDTH-1:0] d_q, d_d;
    logic             cmp_q, done_q;

    logic             accept, is_last, last_step;
    logic [SLICE-1:0] slice_res;
    logic             slice_cy, slice_cmp;

    assign accept    = (state_q == ST_IDLE) && start;
    assign is_last   = (cnt_q == LAST);
    assign last_step = (state_q == ST_RUN) && is_last;

    serial_alu_slice #(.SLICE(SLICE)) u_slice (
        .op      (op_q),
        .a_s     (a_q[SLICE-1:0]),
        .b_s     (b_q[SLICE-1:0]),
        .cy_in   (cy_q),
        .cmp_in  (chain_q),
        .is_last (is_last),
        .res     (slice_res),
        .cy_out  (slice_cy),
        .cmp_out (slice_cmp)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_RUN;
            ST_RUN:  if (is_last) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = done_q;
        d    = d_q;
        cmp  = cmp_q;
    end

    // Compares return a single-bit result, so their last write replaces the whole word.
    always_comb begin
        d_d = d_q;
        d_d[int'(cnt_q) * SLICE +: SLICE] = slice_res;
        if (is_last && op_q[2:1] == 2'b01) begin
            d_d    = '0;
            d_d[0] = slice_cmp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            chain_q <= 1'b0;
            d_q     <= '0;
            cmp_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_step;
            if (accept) begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                cnt_q   <= '0;
                cy_q    <= carry_seed(op);
                chain_q <= 1'b1;
            end else if (state_q == ST_RUN) begin
                a_q     <= a_q >> SLICE;
                b_q     <= b_q >> SLICE;
                cnt_q   <= cnt_q + CW'(1);
                cy_q    <= slice_cy;
                chain_q <= slice_cmp;
                d_q     <= d_d;
                if (is_last) cmp_q <= slice_cmp;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: 32/4 main instance plus 16/8 and 8/8 instances,
// checked through an expected-result queue filled when each op is driven.
module tb_serial_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, cmp;
    logic [31:0] d;

    logic        start16 = 1'b0;
    logic [3:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cmp16;
    logic [15:0] d16;

    logic        start8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cmp8;
    logic [7:0]  d8;

    logic [32:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    serial_alu_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .cmp(cmp)
    );

    serial_alu_seq #(.WIDTH(16), .SLICE(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .d(d16), .cmp(cmp16)
    );

    serial_alu_seq #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .cmp(cmp8)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: returns {cmp, d} for a w-bit ALU.
    function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] aa,
                                          input logic [31:0] bb, input int w);
        logic [31:0] mask, r;
        logic        c, lt;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa = aa & mask;
        bb = bb & mask;
        lt = (aa[w-1] != bb[w-1]) ? aa[w-1] : (aa < bb);
        r  = '0;
        c  = 1'b0;
        case (o)
            4'b0000: begin r = (aa + bb) & mask; c = (r == 0); end
            4'b1000: begin r = (aa - bb) & mask; c = (r == 0); end
            4'b0010: begin c = lt;        r = {31'b0, c}; end
            4'b0011: begin c = (aa < bb); r = {31'b0, c}; end
            4'b0100: r = aa ^ bb;
            4'b0110: r = aa | bb;
            4'b0111: r = aa & bb;
            default: begin r = '0; c = 1'b0; end
        endcase
        return {c, r};
    endfunction

    // Called at a negedge; returns at the negedge where done was seen.
    task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] ed, input logic ec);
        logic [32:0] e;
        int n, busy_n;
        exp_q.push_back({ec, ed});
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        n = 0; busy_n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (done) break;
        end
        e = exp_q.pop_front();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s timeout: no done within %0d cycles", name, n);
        end else begin
            tests += 4;
            if (n !== 9) begin
                fails++; $display("FAIL %s latency: got %0d need 9", name, n);
            end
            if (busy_n !== 8) begin
                fails++; $display("FAIL %s busy cycles: got %0d need 8", name, busy_n);
            end
            if (d !== e[31:0]) begin
                fails++; $display("FAIL %s d: got %h need %h", name, d, e[31:0]);
            end
            if (cmp !== e[32]) begin
                fails++; $display("FAIL %s cmp: got %b need %b", name, cmp, e[32]);
            end
        end
    endtask

    // sel 0: 16/8 instance (2 slices), sel 1: 8/8 instance (1 slice).
    task automatic do_small(input int sel, input string name, input logic [3:0] o,
                            input logic [31:0] aa, input logic [31:0] bb,
                            input logic [31:0] ed, input logic ec);
        logic [32:0] e;
        logic [31:0] got_d;
        logic        got_done, got_cmp;
        int n, nsl;
        nsl = (sel == 0) ? 2 : 1;
        exp_q.push_back({ec, ed});
        if (sel == 0) begin start16 = 1'b1; op16 = o; a16 = aa[15:0]; b16 = bb[15:0]; end
        else          begin start8  = 1'b1; op8  = o; a8  = aa[7:0];  b8  = bb[7:0];  end
        @(posedge clk); #1;
        start16 = 1'b0; start8 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        got_done = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            got_done = (sel == 0) ? done16 : done8;
            if (got_done) break;
        end
        got_d   = (sel == 0) ? {16'b0, d16} : {24'b0, d8};
        got_cmp = (sel == 0) ? cmp16 : cmp8;
        e = exp_q.pop_front();
        tests++;
        if (got_done !== 1'b1) begin
            fails++; $display("FAIL %s timeout: no done within %0d cycles", name, n);
        end else begin
            tests += 3;
            if (n !== nsl + 1) begin
                fails++; $display("FAIL %s latency: got %0d need %0d", name, n, nsl + 1);
            end
            if (got_d !== e[31:0]) begin
                fails++; $display("FAIL %s d: got %h need %h", name, got_d, e[31:0]);
            end
            if (got_cmp !== e[32]) begin
                fails++; $display("FAIL %s cmp: got %b need %b", name, got_cmp, e[32]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 2;
        if ({busy, done, cmp, d} !== 35'b0) begin
            fails++; $display("FAIL reset main: got busy=%b done=%b cmp=%b d=%h need all 0",
                              busy, done, cmp, d);
        end
        if ({busy16, done16, cmp16, d16, busy8, done8, cmp8, d8} !== 30'b0) begin
            fails++; $display("FAIL reset small: got d16=%h d8=%h need 0", d16, d8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        do_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        do_op("sub_neg",  4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op("sub_zero", 4'b1000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1);
        do_op("add_mid",  4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    endtask

    task automatic test_compare();
        do_op("sltu_big",  4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0);
        do_op("slt_pos",   4'b0010, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
        do_op("slt_neg",   4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 1'b1);
        // No start: result and flag must hold.
        repeat (3) @(negedge clk);
        tests += 2;
        if (done !== 1'b0) begin
            fails++; $display("FAIL hold done: got %b need 0", done);
        end
        if (d !== 32'h1 || cmp !== 1'b1) begin
            fails++; $display("FAIL hold d/cmp: got %h/%b need 00000001/1", d, cmp);
        end
    endtask

    task automatic test_logic();
        do_op("and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        do_op("or",  4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        do_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        do_op("bad_op", 4'b0001, 32'h0000_0003, 32'h0000_0004, 32'h0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        logic [32:0] e;
        int dones, first_n;
        exp_q.push_back({1'b0, 32'h3333_3333});
        start = 1'b1; op = 4'b0000; a = 32'h1111_1111; b = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; first_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_n == 0) first_n = n;
                if (dones == 1) begin
                    e = exp_q.pop_front();
                    tests += 2;
                    if (d !== e[31:0]) begin
                        fails++; $display("FAIL busy_ignore d: got %h need %h", d, e[31:0]);
                    end
                    if (cmp !== e[32]) begin
                        fails++; $display("FAIL busy_ignore cmp: got %b need %b", cmp, e[32]);
                    end
                end
            end
            if (n == 2 || n == 4) begin
                start = 1'b1; op = 4'b1000; a = 32'hAAAA_0000 + 32'(n); b = 32'h0000_5555;
            end else begin
                start = 1'b0;
            end
        end
        tests += 2;
        if (dones !== 1) begin
            fails++; $display("FAIL busy_ignore dones: got %0d need 1", dones);
        end
        if (first_n !== 9) begin
            fails++; $display("FAIL busy_ignore latency: got %0d need 9", first_n);
        end
        while (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid_run();
        int dones;
        start = 1'b1; op = 4'b0000; a = 32'h1234_5678; b = 32'h1111_1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, cmp, d} !== 35'b0) begin
            fails++; $display("FAIL mid_reset: got busy=%b done=%b cmp=%b d=%h need all 0",
                              busy, done, cmp, d);
        end
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++; $display("FAIL mid_reset discard: got %0d active cycles need 0", dones);
        end
        do_op("and_after_rst", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[3];
        logic [31:0] as[3], bs[3];
        logic [32:0] e;
        int n;
        for (int i = 0; i < 3; i++) begin
            ops[i] = (i == 1) ? 4'b1000 : 4'b0000;
            as[i]  = $urandom;
            bs[i]  = $urandom;
        end
        exp_q.push_back(model(ops[0], as[0], bs[0], 32));
        start = 1'b1; op = ops[0]; a = as[0]; b = bs[0];
        @(posedge clk); #1;
        exp_q.push_back(model(ops[1], as[1], bs[1], 32));
        op = ops[1]; a = as[1]; b = bs[1];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (n < 40) begin
                @(negedge clk);
                n++;
                if (done) break;
            end
            e = exp_q.pop_front();
            tests += 3;
            if (done !== 1'b1 || n !== 9) begin
                fails++; $display("FAIL b2b%0d spacing: got %0d cycles need 9", i, n);
            end
            if (d !== e[31:0]) begin
                fails++; $display("FAIL b2b%0d d: got %h need %h", i, d, e[31:0]);
            end
            if (cmp !== e[32]) begin
                fails++; $display("FAIL b2b%0d cmp: got %b need %b", i, cmp, e[32]);
            end
            if (i == 2) begin
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
                if (i == 0) begin
                    exp_q.push_back(model(ops[2], as[2], bs[2], 32));
                    op = ops[2]; a = as[2]; b = bs[2];
                end else begin
                    a = $urandom; b = $urandom;
                end
            end
        end
    endtask

    task automatic test_param_sweep();
        logic [3:0]  o;
        logic [31:0] ra, rb;
        logic [32:0] m;
        do_small(0, "w16_add", 4'b0000, 32'h00FF, 32'h0001, 32'h0100, 1'b0);
        do_small(1, "w8_add",  4'b0000, 32'hFF,   32'h01,   32'h00,   1'b1);
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 12; i++) begin
                o  = 4'($urandom_range(0, 15));
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                m  = model(o, ra, rb, (sel == 0) ? 16 : 8);
                do_small(sel, "small_rand", o, ra, rb, m[31:0], m[32]);
            end
        end
    endtask

    task automatic test_random_main();
        logic [3:0]  o;
        logic [31:0] ra, rb;
        logic [32:0] m;
        for (int i = 0; i < 16; i++) begin
            o  = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            m  = model(o, ra, rb, 32);
            do_op("main_rand", o, ra, rb, m[31:0], m[32]);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_logic();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_param_sweep();
        test_random_main();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Parametrised bit-serial ALU sequencer: accepts a full-width operation on a start strobe and walks the operands LSB-first, SLICE bits per cycle, through a combinational slice ALU.
- Carry and compare chains are registered between slices.
- Produces a WIDTH-bit result plus compare flag with a busy/done handshake; the result register holds until the next accepted start.
- Generalises the fixed 32-bit/4-bit nibble datapath so narrower or wider slices can trade area against latency.

Parameters:
WIDTH, 32, operand/result width in bits
SLICE, 4, bits processed per cycle; power of two, must divide WIDTH (elaboration error otherwise)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  request strobe; sampled only while idle
op  in  4  operation code, captured on accepted start
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
busy  out  1  high while slices are being processed
done  out  1  one-cycle pulse; d/cmp valid from this cycle
d  out  WIDTH  result register
cmp  out  1  compare/zero flag register

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-operation): state IDLE; busy=0, done=0, d=0, cmp=0; slice counter=0; any in-flight operation is discarded.
- Op encoding:
  - 0000 ADD (cy0=0)
  - 1000 SUB (cy0=1, B inverted)
  - 0010 SLT (cy0=1, B inverted)
  - 0011 SLTU (cy0=1, B inverted)
  - 0100 XOR
  - 0110 OR
  - 0111 AND
  - Other codes: d=0, cmp=0.
  - Carry seed rule: cy0 = op[1] | op[3].
- States: IDLE, RUN.
  - IDLE, start=1: capture op/a/b; counter=0, cy=cy0, cmp chain=1; go RUN; busy=1 next cycle. done=0.
  - RUN: each cycle, slice k=counter processes bits [k*SLICE +: SLICE]. Slice result is written into d at that position. Registered cy and cmp are updated. counter increments.
  - RUN, last slice (counter=WIDTH/SLICE-1): go IDLE; busy=0 and done=1 the following cycle.
- Latency: start accepted at edge T; done high during cycle T+WIDTH/SLICE; busy high for exactly WIDTH/SLICE cycles.
- d is updated progressively during RUN; it is only guaranteed when done=1 and is held unchanged until the next accepted start.
- cmp semantics:
  - ADD/SUB: cmp = 1 iff full result == 0 (chain is the AND of per-slice zero flags).
  - SLTU: cmp = NOT final carry-out.
  - SLT: cmp = a[W-1] if a[W-1] != b[W-1], else NOT final carry-out.
  - Logic ops: cmp = 0.
- For op[2:1]==01 (SLT/SLTU), the final-slice write sets d = {WIDTH-1 zeros, cmp}, overriding all earlier slice writes.
- Arithmetic is modulo 2^WIDTH; overflow is not flagged.
- start while busy: ignored, with no effect on the in-flight operation. start in the done cycle is accepted (state is IDLE then).
- start held high continuously: back-to-back operations, one every WIDTH/SLICE+1 cycles.
- SLICE==WIDTH: single RUN cycle; done one cycle after start.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package serial_alu_pkg holds:
  - op-code localparams (OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND);
  - a state enum (ST_IDLE, ST_RUN);
  - a function computing cy0 from op.
- One sub-module, serial_alu_slice (parameter SLICE), combinational:
  - inputs: op, a_s, b_s, cy_in, cmp_in, is_last;
  - outputs: res, cy_out, cmp_out.
- The sequencer owns the counter, capture registers, chains and handshake.

Test Plan:
- ADD a=0xFFFFFFFF b=0x00000001, WIDTH=32 SLICE=4 -> done exactly 8 cycles after start edge, d=0x00000000, cmp=1; busy high 8 cycles.
- SUB a=5 b=7 -> d=0xFFFFFFFE, cmp=0. SUB a=b=0x12345678 -> d=0, cmp=1.
- SLT a=0xFFFFFFFF b=1 -> d=1, cmp=1. SLTU same operands -> d=0, cmp=0. SLT a=0x7FFFFFFF b=0x80000000 -> d=0.
- start pulses at cycles 2 and 4 of a running ADD with different operands -> only the first result appears; no second done; a start in the done cycle is accepted.
- rst asserted at cycle 3 of a RUN -> next cycle busy=0, done=0, d=0, cmp=0; a subsequent AND 0xF0F0F0F0 & 0xFF00FF00 -> d=0xF000F000, cmp=0.
- Parameter sweep WIDTH=16 SLICE=8 and WIDTH=8 SLICE=8: ADD 0x00FF+0x0001 -> d=0x0100 after 2 cycles; 0xFF+0x01 -> d=0x00, cmp=1 after 1 cycle; randomised ops checked against a reference model.
